// File: rtl/text_scroll_sequencer.sv
// Arbitrates the scrolling text display between two requesters, streams the
// granted message into it, then issues column-play steps for the requested passes.
//
// state | meaning
// IDLE  | no owner; round-robin grant on any request
// LOAD  | accepting characters from the owner, one display step per accept
// PAD   | owner abandoned mid-load; fill the rest of the buffer with 7'h00
// PLAY  | prescaled 7'h7F column steps until steps_left runs out or owner leaves
module text_scroll_sequencer #(
  parameter int WORD_COUNT = 20,
  parameter int STEP_DIV   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_0,
  input  logic       req_1,
  input  logic [6:0] ch_0,
  input  logic [6:0] ch_1,
  input  logic       vld_0,
  input  logic       vld_1,
  output logic       rdy_0,
  output logic       rdy_1,
  input  logic [3:0] loops,
  output logic [1:0] grant,
  output logic       busy,
  output logic       done_0,
  output logic       done_1,
  output logic [6:0] disp_din,
  output logic       disp_step
);

  localparam int PL_W  = $clog2(8 * WORD_COUNT + 1);
  localparam int SL_W  = PL_W + 4;
  localparam int CNT_W = $clog2(WORD_COUNT + 1);
  localparam int PS_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, PAD, PLAY} state_t;

  state_t            state;
  logic              owner;
  logic              prio;
  logic [3:0]        loops_q;
  logic [CNT_W-1:0]  cnt;
  logic [PL_W-1:0]   pass_len;
  logic [SL_W-1:0]   steps_left;
  logic [PS_W-1:0]   presc;

  logic              req_sel;
  logic              vld_sel;
  logic              rdy_sel;
  logic [6:0]        ch_sel;
  logic [6:0]        ch_san;
  logic              accept;
  logic [PL_W-1:0]   pl_add;
  logic [PL_W-1:0]   pl_next;
  logic              presc_tc;
  logic              last_char;
  logic              pick;

  assign req_sel   = owner ? req_1 : req_0;
  assign vld_sel   = owner ? vld_1 : vld_0;
  assign rdy_sel   = owner ? rdy_1 : rdy_0;
  assign ch_sel    = owner ? ch_1  : ch_0;
  assign accept    = vld_sel & rdy_sel;
  // 7'h7F is reserved as the play command, so it is shown as a blank glyph
  assign ch_san    = (ch_sel == 7'h7F) ? 7'h40 : ch_sel;
  assign pl_add    = ch_san[6] ? PL_W'(8) : PL_W'(1);
  assign pl_next   = pass_len + pl_add;
  assign presc_tc  = (presc == PS_W'(STEP_DIV - 1));
  assign last_char = (cnt == CNT_W'(WORD_COUNT - 1));
  assign pick      = prio ? req_1 : ~req_0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      prio       <= 1'b0;
      loops_q    <= 4'd0;
      cnt        <= '0;
      pass_len   <= '0;
      steps_left <= '0;
      presc      <= '0;
      grant      <= 2'b00;
      busy       <= 1'b0;
      rdy_0      <= 1'b0;
      rdy_1      <= 1'b0;
      done_0     <= 1'b0;
      done_1     <= 1'b0;
      disp_din   <= 7'h00;
      disp_step  <= 1'b0;
    end else begin
      disp_step <= 1'b0;
      disp_din  <= 7'h00;
      done_0    <= 1'b0;
      done_1    <= 1'b0;
      case (state)
        IDLE: begin
          if (req_0 | req_1) begin
            owner    <= pick;
            prio     <= ~pick;
            grant    <= pick ? 2'b10 : 2'b01;
            busy     <= 1'b1;
            rdy_0    <= ~pick;
            rdy_1    <= pick;
            loops_q  <= (loops == 4'd0) ? 4'd1 : loops;
            cnt      <= '0;
            pass_len <= '0;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (accept) begin
            disp_step <= 1'b1;
            disp_din  <= ch_san;
            cnt       <= cnt + 1'b1;
            pass_len  <= pl_next;
          end
          // an accept in the same cycle as an abandon still counts toward the buffer
          if (accept && last_char) begin
            steps_left <= SL_W'(pl_next) * SL_W'(loops_q);
            presc      <= '0;
            rdy_0      <= 1'b0;
            rdy_1      <= 1'b0;
            state      <= PLAY;
          end else if (!req_sel) begin
            rdy_0 <= 1'b0;
            rdy_1 <= 1'b0;
            state <= PAD;
          end
        end
        PAD: begin
          disp_step <= 1'b1;
          disp_din  <= 7'h00;
          cnt       <= cnt + 1'b1;
          if (last_char) begin
            grant <= 2'b00;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        PLAY: begin
          if (steps_left == '0) begin
            done_0 <= ~owner;
            done_1 <= owner;
            grant  <= 2'b00;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            presc <= presc_tc ? '0 : presc + 1'b1;
            if (presc_tc) begin
              if (!req_sel) begin
                grant <= 2'b00;
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
                disp_step  <= 1'b1;
                disp_din   <= 7'h7F;
                steps_left <= steps_left - 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_scroll_sequencer.sv
// Directed/randomised bench for text_scroll_sequencer: records every display
// step and done pulse, then compares against message-level expectations.
module tb_text_scroll_sequencer;

  localparam int WC = 20;
  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_0 = 1'b0, req_1 = 1'b0;
  logic [6:0] ch_0 = '0, ch_1 = '0;
  logic       vld_0 = 1'b0, vld_1 = 1'b0;
  logic       rdy_0, rdy_1;
  logic [3:0] loops = '0;
  logic [1:0] grant;
  logic       busy, done_0, done_1;
  logic [6:0] disp_din;
  logic       disp_step;

  text_scroll_sequencer #(.WORD_COUNT(WC), .STEP_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_0(req_0), .req_1(req_1),
    .ch_0(ch_0), .ch_1(ch_1),
    .vld_0(vld_0), .vld_1(vld_1),
    .rdy_0(rdy_0), .rdy_1(rdy_1),
    .loops(loops), .grant(grant), .busy(busy),
    .done_0(done_0), .done_1(done_1),
    .disp_din(disp_din), .disp_step(disp_step)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; logic [6:0] din;} step_t;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         din_bad = 0;
  int         done_cnt [2];
  int         done_cyc = 0;
  step_t      step_q [$];
  logic [1:0] grant_q [$];
  logic [1:0] prev_grant = 2'b00;
  logic [6:0] msg [WC];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (disp_step) step_q.push_back('{cyc, disp_din});
    else if (disp_din !== 7'h00) din_bad++;
    if (done_0) begin done_cnt[0]++; done_cyc = cyc; end
    if (done_1) begin done_cnt[1]++; done_cyc = cyc; end
    if (grant != 2'b00 && prev_grant == 2'b00) grant_q.push_back(grant);
    prev_grant = grant;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] sanit(input logic [6:0] c);
    return (c == 7'h7F) ? 7'h40 : c;
  endfunction

  function automatic logic rdy_of(input int who);
    return (who == 0) ? rdy_0 : rdy_1;
  endfunction

  task automatic drive(input int who, input logic v, input logic [6:0] c);
    if (who == 0) begin vld_0 = v; ch_0 = c; end
    else          begin vld_1 = v; ch_1 = c; end
  endtask

  task automatic set_req(input int who, input logic r);
    if (who == 0) req_0 = r; else req_1 = r;
  endtask

  function automatic logic [15:0] out_vec();
    return {1'b0, grant, busy, rdy_0, rdy_1, done_0, done_1, disp_din, disp_step};
  endfunction

  // Plays the message in msg[] through one requester and checks the recorded stream.
  task automatic run_txn(input int who, input int lp, input bit stall,
                         input int abandon_at, input int play_ab);
    int idx, t, t_idle, exp_play, bad, drop_cyc, n_load, play_n, last_cyc;
    int acc_cyc [$];
    logic [1:0] oh;
    logic [6:0] s;
    logic v;
    oh = (who == 0) ? 2'b01 : 2'b10;
    step_q.delete();
    done_cnt[0] = 0; done_cnt[1] = 0;
    exp_play = 0;
    for (int i = 0; i < WC; i++) begin
      s = sanit(msg[i]);
      exp_play += s[6] ? 8 : 1;
    end
    exp_play *= (lp == 0) ? 1 : lp;

    @(negedge clk);
    loops = 4'(lp);
    set_req(who, 1'b1);
    t = 0;
    do begin @(negedge clk); t++; end while (grant != oh && t < 20);
    check("grant_owner", grant, oh);
    loops = 4'($urandom_range(0, 15));

    idx = 0; t = 0;
    while (idx < WC && !(abandon_at >= 0 && idx == abandon_at) && t < 500) begin
      v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      drive(who, v, msg[idx]);
      if (v && rdy_of(who)) begin acc_cyc.push_back(cyc); idx++; end
      @(negedge clk); t++;
    end
    drive(who, 1'b0, 7'h00);
    drop_cyc = cyc;
    if (abandon_at >= 0) set_req(who, 1'b0);
    if (play_ab > 0) begin
      t = 0;
      while (step_q.size() < WC + play_ab && t < 5000) begin @(negedge clk); t++; end
      set_req(who, 1'b0);
      drop_cyc = cyc;
    end
    t_idle = 0;
    while (busy && t_idle < 12000) begin @(negedge clk); t_idle++; end
    set_req(who, 1'b0);
    check("busy_released", busy, 1'b0);
    repeat (3) @(negedge clk);

    n_load = (abandon_at >= 0) ? abandon_at : WC;
    bad = 0;
    for (int i = 0; i < n_load; i++) begin
      if (i >= step_q.size() || i >= acc_cyc.size()) bad++;
      else if (step_q[i].din !== sanit(msg[i]) || step_q[i].cyc != acc_cyc[i] + 1) bad++;
    end
    check("load_stream", bad, 0);
    last_cyc = (step_q.size() > 0) ? step_q[step_q.size()-1].cyc : 0;

    if (abandon_at >= 0) begin
      check("pad_total", step_q.size(), WC);
      bad = 0;
      for (int i = n_load; i < step_q.size(); i++) if (step_q[i].din !== 7'h00) bad++;
      check("pad_zero", bad, 0);
      check("abandon_load_done", done_cnt[who], 0);
    end else begin
      play_n = step_q.size() - WC;
      bad = 0;
      for (int i = WC; i < step_q.size(); i++)
        if (step_q[i].din !== 7'h7F || step_q[i].cyc - step_q[i-1].cyc != SD) bad++;
      check("play_spacing", bad, 0);
      if (play_ab == 0) begin
        check("play_count", play_n, exp_play);
        check("done_count", done_cnt[who], 1);
        check("done_timing", done_cyc, last_cyc + 1);
      end else begin
        check("abandon_play_stop", last_cyc <= drop_cyc, 1'b1);
        check("abandon_play_latency", t_idle <= SD, 1'b1);
        check("abandon_play_short", play_n < exp_play, 1'b1);
        check("abandon_play_done", done_cnt[who], 0);
      end
    end
    check("other_done", done_cnt[1-who], 0);
    check("grant_idle", grant, 2'b00);
  endtask

  initial begin
    int t, idx, j;
    logic [6:0] tmp;
    done_cnt[0] = 0; done_cnt[1] = 0;

    req_0 = 1'b1; req_1 = 1'b1; vld_0 = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", out_vec(), 16'h0);
    req_0 = 1'b0; req_1 = 1'b0; vld_0 = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // all font glyphs, one pass
    for (int i = 0; i < WC; i++) msg[i] = 7'h41;
    run_txn(0, 1, 1'b0, -1, 0);

    // 10 raw + 10 glyph columns, shuffled, three passes
    for (int i = 0; i < WC; i++)
      msg[i] = (i < 10) ? 7'($urandom_range(0, 63)) : 7'($urandom_range(64, 126));
    for (int i = WC - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = msg[i]; msg[i] = msg[j]; msg[j] = tmp;
    end
    run_txn(1, 3, 1'b0, -1, 0);

    // sanitise with vld toggling, loops=0 plays once
    for (int i = 0; i < WC; i++) msg[i] = 7'($urandom_range(0, 127));
    msg[5] = 7'h7F;
    run_txn(0, 0, 1'b1, -1, 0);

    // abandon in LOAD after 7 characters
    for (int i = 0; i < WC; i++) msg[i] = 7'($urandom_range(0, 127));
    run_txn(1, 2, 1'b0, 7, 0);

    // abandon in PLAY after 5 play steps
    for (int i = 0; i < WC; i++) msg[i] = 7'($urandom_range(0, 127));
    run_txn(0, 2, 1'b1, -1, 5);

    // reset mid-PLAY, then a fresh load
    for (int i = 0; i < WC; i++) msg[i] = 7'($urandom_range(0, 127));
    @(negedge clk);
    req_0 = 1'b1; loops = 4'd2;
    t = 0;
    do begin @(negedge clk); t++; end while (grant != 2'b01 && t < 20);
    idx = 0; t = 0;
    while (idx < WC && t < 100) begin
      drive(0, 1'b1, msg[idx]);
      if (rdy_0) idx++;
      @(negedge clk); t++;
    end
    drive(0, 1'b0, 7'h00);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_mid_play", out_vec(), 16'h0);
    rst_n = 1'b1; req_0 = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < WC; i++) msg[i] = 7'($urandom_range(0, 127));
    run_txn(0, $urandom_range(1, 4), 1'b1, -1, 0);

    // round-robin with both requests held, starting from reset priority
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    grant_q.delete();
    ch_0 = 7'h01; ch_1 = 7'h02; vld_0 = 1'b1; vld_1 = 1'b1; loops = 4'd1;
    req_0 = 1'b1; req_1 = 1'b1;
    t = 0;
    while (grant_q.size() < 3 && t < 2000) begin @(negedge clk); t++; end
    req_0 = 1'b0; req_1 = 1'b0; vld_0 = 1'b0; vld_1 = 1'b0;
    check("arb_grant_count", grant_q.size() >= 3, 1'b1);
    if (grant_q.size() >= 3) begin
      check("arb_first", grant_q[0], 2'b01);
      check("arb_second", grant_q[1], 2'b10);
      check("arb_third", grant_q[2], 2'b01);
    end
    t = 0;
    while (busy && t < 200) begin @(negedge clk); t++; end
    check("arb_idle", busy, 1'b0);

    // priority now sits with requester 1; reset must hand it back to 0
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_0 = 1'b1; req_1 = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (grant == 2'b00 && t < 20);
    check("reset_priority", grant, 2'b01);
    req_0 = 1'b0; req_1 = 1'b0;
    t = 0;
    while (busy && t < 200) begin @(negedge clk); t++; end
    check("pad_idle", busy, 1'b0);

    check("din_zero_when_idle", din_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
